// File: rtl/sd4_mac_seq_ctrl.sv
// SD4 MAC sequencer: feeds tiles into the input register, tracks them
// through the multiply pipe and hands the accumulated result to writeback.
module sd4_mac_seq_ctrl #(
    parameter int MAC_LAT = 3,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ld_en,
    output logic             bias_ld,
    output logic             acc_en,
    output logic             acc_first,
    output logic             acc_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        OUT
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [MAC_LAT-1:0] pv_q, pv_d;
    logic [MAC_LAT-1:0] pf_q, pf_d;
    logic [MAC_LAT-1:0] pl_q, pl_d;
    logic               tile_last;

    assign tile_last = (cnt_q == (len_q - LEN_W'(1)));
    assign ld_en     = in_valid & in_ready;
    assign acc_en    = pv_q[MAC_LAT-1];
    assign acc_first = pf_q[MAC_LAT-1];
    assign acc_last  = pl_q[MAC_LAT-1];
    assign busy      = (state_q != IDLE);

    // Next-state and handshake outputs of the job sequencer
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        bias_ld   = 1'b0;
        cfg_err   = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        bias_ld = 1'b1;
                        state_d = FEED;
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            FEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (tile_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (acc_en && acc_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipe tracker: tag each accepted tile and shift it every cycle
    always_comb begin
        pv_d    = pv_q;
        pf_d    = pf_q;
        pl_d    = pl_q;
        pv_d[0] = ld_en;
        pf_d[0] = ld_en & (cnt_q == '0);
        pl_d[0] = ld_en & tile_last;
        for (int i = 1; i < MAC_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pf_d[i] = pf_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
    end

    // State, counters and pipe tags; reset discards in-flight tiles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            pv_q    <= '0;
            pf_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pv_q    <= pv_d;
            pf_q    <= pf_d;
            pl_q    <= pl_d;
        end
    end

endmodule

// File: tb/tb_sd4_mac_seq_ctrl.sv
// Testbench for sd4_mac_seq_ctrl: directed scenarios plus random jobs,
// all checked against a tile/event-level reference model.
module tb_sd4_mac_seq_ctrl;

    localparam int MAC_LAT = 3;
    localparam int LEN_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic             ld_en;
    logic             bias_ld;
    logic             acc_en;
    logic             acc_first;
    logic             acc_last;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic             cfg_err;

    sd4_mac_seq_ctrl #(
        .MAC_LAT(MAC_LAT),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ld_en    (ld_en),
        .bias_ld  (bias_ld),
        .acc_en   (acc_en),
        .acc_first(acc_first),
        .acc_last (acc_last),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit f;
        bit l;
    } ev_t;

    // Reference model: a job is active from start until its last product
    // lands; tiles are accepted while fewer than len have been taken; each
    // accepted tile produces one accumulator event MAC_LAT cycles later.
    ev_t  evq[$];
    bit   m_job;
    bit   m_res;
    int   m_len;
    int   m_acc;
    int   cyc;

    int   n_cmp;
    int   n_bad;

    // {in_ready, ld_en, bias_ld, acc_en, acc_first, acc_last,
    //  res_valid, busy, cfg_err}
    logic [8:0] obs;
    logic [8:0] exp;

    task automatic model_clear();
        evq.delete();
        m_job = 1'b0;
        m_res = 1'b0;
        m_len = 0;
        m_acc = 0;
    endtask

    // Drive one cycle, predict its outputs, sample DUT, advance model.
    task automatic cycle(input bit st, input int ln, input bit vi,
                         input bit rr, input bit r);
        bit feed, idle, acc, f, l;
        @(posedge clk);
        #1;
        cyc++;
        rst       = r;
        start     = st;
        cfg_len   = ln[LEN_W-1:0];
        in_valid  = vi;
        res_ready = rr;
        feed = m_job && (m_acc < m_len);
        idle = !m_job && !m_res;
        acc  = 1'b0;
        f    = 1'b0;
        l    = 1'b0;
        if (evq.size() > 0 && evq[0].c == cyc) begin
            acc = 1'b1;
            f   = evq[0].f;
            l   = evq[0].l;
        end
        exp = {feed, feed & vi, idle & st & (ln != 0), acc, f, l,
               m_res, !idle, idle & st & (ln == 0)};
        @(negedge clk);
        obs = {in_ready, ld_en, bias_ld, acc_en, acc_first, acc_last,
               res_valid, busy, cfg_err};
        if (r) begin
            model_clear();
        end else begin
            if (acc) void'(evq.pop_front());
            if (feed && vi) begin
                evq.push_back('{c: cyc + MAC_LAT, f: (m_acc == 0),
                                l: (m_acc == m_len - 1)});
                m_acc++;
            end
            if (m_res && rr) m_res = 1'b0;
            if (l) begin
                m_job = 1'b0;
                m_res = 1'b1;
            end
            if (idle && st && ln != 0) begin
                m_job = 1'b1;
                m_len = ln;
                m_acc = 0;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== 9'b0) begin
                n_bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", cyc, obs, 9'b0);
            end
        end
    endtask

    task automatic test_basic();
        int accs;
        accs = 0;
        cycle(1'b1, 4, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL basic cyc=%0d got=%b want=%b", cyc, obs, exp);
        end
        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
            accs += int'(acc_en);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL basic cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
        n_cmp++;
        if (accs !== 4) begin
            n_bad++;
            $display("FAIL basic_acc_count got=%0d want=4", accs);
        end
    endtask

    task automatic test_gaps();
        bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cycle(1'b1, 3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 0, (i < 5) ? pat[i] : 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL gaps cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_len1();
        cycle(1'b1, 1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL len1 cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle((i >= 6 && i <= 10), 3, 1'b1, (i >= 11), 1'b0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL backpressure cyc=%0d got=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_cfg_err();
        for (int i = 0; i < 4; i++) begin
            cycle((i == 1), 0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL cfg_err cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 4, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_mid cyc=%0d got=%b want=%b", cyc, obs, 9'b0);
        end
        cycle(1'b1, 2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_mid cyc=%0d got=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1 + (i % 3), 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) == 0,
                  ($urandom % 8 == 0) ? int'($urandom % 256)
                                      : int'($urandom % 6),
                  ($urandom % 3) != 0,
                  ($urandom % 2) == 0,
                  ($urandom % 250) == 0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        model_clear();
        test_reset();
        test_basic();
        settle();
        test_gaps();
        settle();
        test_len1();
        settle();
        test_backpressure();
        settle();
        test_cfg_err();
        settle();
        test_reset_mid();
        settle();
        test_back_to_back();
        settle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
